// File: rtl/cpu_pkg.sv
// Shared CPU pipeline types: default widths and the EX/MEM control bundles.
package cpu_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned RW_DEF    = 5;
    localparam int unsigned CNT_W_DEF = 16;

    // Write-back stage control.
    typedef struct packed {
        logic jal;
        logic memtoreg;
        logic regwrite;
        logic regdst;
        logic lui;
    } wb_ctrl_t;

    // Memory stage control.
    typedef struct packed {
        logic memwrite;
        logic lb;
    } mem_ctrl_t;

    // Everything cleared by a flush: entry valid plus both control bundles.
    typedef struct packed {
        logic      valid;
        wb_ctrl_t  wb;
        mem_ctrl_t mem;
    } ex_mem_ctrl_t;

    localparam int unsigned CTRL_W = $bits(ex_mem_ctrl_t);

endpackage

// File: rtl/ex_mem_reg_if.sv
// EX/MEM stage bus: EX-side inputs, MEM-side registered outputs and hazard exports.
interface ex_mem_reg_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned RW    = 5,
    parameter int unsigned CNT_W = 16
);
    logic             stall_i;
    logic             flush_i;
    logic             valid_i;
    logic [RW-1:0]    rw_i;
    logic             jal_i;
    logic             memwrite_i;
    logic             memtoreg_i;
    logic             regwrite_i;
    logic             regdst_i;
    logic             lb_i;
    logic             lui_i;
    logic [XLEN-1:0]  b_i;
    logic [XLEN-1:0]  imm_i;
    logic [XLEN-1:0]  pc_i;
    logic [XLEN-1:0]  alu_i;

    logic             valid_o;
    logic [RW-1:0]    rw_o;
    logic             jal_o;
    logic             memwrite_o;
    logic             memtoreg_o;
    logic             regwrite_o;
    logic             regdst_o;
    logic             lb_o;
    logic             lui_o;
    logic [XLEN-1:0]  b_o;
    logic [XLEN-1:0]  imm_o;
    logic [XLEN-1:0]  pc_o;
    logic [XLEN-1:0]  alu_o;
    logic             fwd_en_o;
    logic [RW-1:0]    fwd_rw_o;
    logic [XLEN-1:0]  fwd_data_o;
    logic             load_hazard_o;
    logic [CNT_W-1:0] stall_cnt_o;

    // EX stage / testbench side.
    modport master (
        output stall_i, flush_i, valid_i, rw_i, jal_i, memwrite_i, memtoreg_i,
               regwrite_i, regdst_i, lb_i, lui_i, b_i, imm_i, pc_i, alu_i,
        input  valid_o, rw_o, jal_o, memwrite_o, memtoreg_o, regwrite_o, regdst_o,
               lb_o, lui_o, b_o, imm_o, pc_o, alu_o, fwd_en_o, fwd_rw_o,
               fwd_data_o, load_hazard_o, stall_cnt_o
    );

    // Pipeline register side.
    modport slave (
        input  stall_i, flush_i, valid_i, rw_i, jal_i, memwrite_i, memtoreg_i,
               regwrite_i, regdst_i, lb_i, lui_i, b_i, imm_i, pc_i, alu_i,
        output valid_o, rw_o, jal_o, memwrite_o, memtoreg_o, regwrite_o, regdst_o,
               lb_o, lui_o, b_o, imm_o, pc_o, alu_o, fwd_en_o, fwd_rw_o,
               fwd_data_o, load_hazard_o, stall_cnt_o
    );

endinterface

// File: rtl/pipe_field_reg.sv
// Generic pipeline field register: clear beats hold beats load.
module pipe_field_reg #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         hold,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Async-reset field register with bubble clear and hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (!hold) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with stall/flush, valid gating, forwarding/load-use
// exports and a saturating stall counter; BYPASS=1 gives the legacy passthrough.
module ex_mem_reg
    import cpu_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEF,
    parameter int unsigned RW     = RW_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF,
    parameter bit          BYPASS = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    ex_mem_reg_if.slave   bus
);

    localparam int unsigned DW = RW + 4 * XLEN;

    ex_mem_ctrl_t     ctrl_raw;
    ex_mem_ctrl_t     ctrl_s;
    logic [DW-1:0]    data_in;
    logic [DW-1:0]    data_s;
    logic [RW-1:0]    rw_s;
    logic [XLEN-1:0]  b_s;
    logic [XLEN-1:0]  imm_s;
    logic [XLEN-1:0]  pc_s;
    logic [XLEN-1:0]  alu_s;
    logic [CNT_W-1:0] cnt_s;
    logic [XLEN-1:0]  fwd_data;
    logic             rw_nz;

    // Collect the EX-side control and data into bundles.
    always_comb begin
        ctrl_raw              = '0;
        ctrl_raw.valid        = bus.valid_i;
        ctrl_raw.wb.jal       = bus.jal_i;
        ctrl_raw.wb.memtoreg  = bus.memtoreg_i;
        ctrl_raw.wb.regwrite  = bus.regwrite_i;
        ctrl_raw.wb.regdst    = bus.regdst_i;
        ctrl_raw.wb.lui       = bus.lui_i;
        ctrl_raw.mem.memwrite = bus.memwrite_i;
        ctrl_raw.mem.lb       = bus.lb_i;
    end

    assign data_in = {bus.rw_i, bus.b_i, bus.imm_i, bus.pc_i, bus.alu_i};

    generate
        if (BYPASS) begin : g_bypass
            // Legacy transparent stage: outputs follow inputs, no counting.
            assign ctrl_s = ctrl_raw;
            assign data_s = data_in;
            assign cnt_s  = '0;
        end else begin : g_reg
            ex_mem_ctrl_t     ctrl_d;
            logic [CNT_W-1:0] cnt_q;

            // Invalid entries must never write memory or the register file.
            always_comb begin
                ctrl_d              = ctrl_raw;
                ctrl_d.mem.memwrite = bus.memwrite_i & bus.valid_i;
                ctrl_d.wb.regwrite  = bus.regwrite_i & bus.valid_i;
            end

            pipe_field_reg #(.W(CTRL_W)) u_ctrl (
                .clk   (clk),
                .rst_n (rst),
                .hold  (bus.stall_i),
                .clear (bus.flush_i),
                .d     (ctrl_d),
                .q     (ctrl_s)
            );

            // Data and destination index survive a flush unchanged.
            pipe_field_reg #(.W(DW)) u_data (
                .clk   (clk),
                .rst_n (rst),
                .hold  (bus.stall_i | bus.flush_i),
                .clear (1'b0),
                .d     (data_in),
                .q     (data_s)
            );

            // Saturating count of stalled (non-flushed) edges.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cnt_q <= '0;
                end else if (bus.stall_i && !bus.flush_i && (cnt_q != {CNT_W{1'b1}})) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end

            assign cnt_s = cnt_q;
        end
    endgenerate

    assign {rw_s, b_s, imm_s, pc_s, alu_s} = data_s;

    // Value the MEM stage would write back: link address, LUI result or ALU.
    always_comb begin
        fwd_data = alu_s;
        if (ctrl_s.wb.jal) begin
            fwd_data = pc_s + XLEN'(1);
        end else if (ctrl_s.wb.lui) begin
            fwd_data = XLEN'({imm_s[15:0], 16'h0000});
        end
    end

    assign rw_nz = |rw_s;

    assign bus.valid_o       = ctrl_s.valid;
    assign bus.rw_o          = rw_s;
    assign bus.jal_o         = ctrl_s.wb.jal;
    assign bus.memwrite_o    = ctrl_s.mem.memwrite;
    assign bus.memtoreg_o    = ctrl_s.wb.memtoreg;
    assign bus.regwrite_o    = ctrl_s.wb.regwrite;
    assign bus.regdst_o      = ctrl_s.wb.regdst;
    assign bus.lb_o          = ctrl_s.mem.lb;
    assign bus.lui_o         = ctrl_s.wb.lui;
    assign bus.b_o           = b_s;
    assign bus.imm_o         = imm_s;
    assign bus.pc_o          = pc_s;
    assign bus.alu_o         = alu_s;
    assign bus.fwd_en_o      = ctrl_s.valid & ctrl_s.wb.regwrite & ~ctrl_s.wb.memtoreg & rw_nz;
    assign bus.fwd_rw_o      = rw_s;
    assign bus.fwd_data_o    = fwd_data;
    assign bus.load_hazard_o = ctrl_s.valid & ctrl_s.wb.regwrite & ctrl_s.wb.memtoreg & rw_nz;
    assign bus.stall_cnt_o   = cnt_s;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed bench for ex_mem_reg: default, narrow-counter and bypass instances.
`timescale 1ns/1ps
module tb_ex_mem_reg;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    ex_mem_reg_if #(.XLEN(32), .RW(5), .CNT_W(16)) m_if ();
    ex_mem_reg_if #(.XLEN(32), .RW(5), .CNT_W(2))  s_if ();
    ex_mem_reg_if #(.XLEN(32), .RW(5), .CNT_W(16)) b_if ();

    ex_mem_reg #(.XLEN(32), .RW(5), .CNT_W(16), .BYPASS(1'b0)) u_main (.clk(clk), .rst(rst), .bus(m_if));
    ex_mem_reg #(.XLEN(32), .RW(5), .CNT_W(2),  .BYPASS(1'b0)) u_sat  (.clk(clk), .rst(rst), .bus(s_if));
    ex_mem_reg #(.XLEN(32), .RW(5), .CNT_W(16), .BYPASS(1'b1)) u_byp  (.clk(clk), .rst(rst), .bus(b_if));

    `define ZERO_IF(x) \
        x.stall_i = 0; x.flush_i = 0; x.valid_i = 0; x.rw_i = 0; x.jal_i = 0; \
        x.memwrite_i = 0; x.memtoreg_i = 0; x.regwrite_i = 0; x.regdst_i = 0; \
        x.lb_i = 0; x.lui_i = 0; x.b_i = 0; x.imm_i = 0; x.pc_i = 0; x.alu_i = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        `ZERO_IF(m_if)
        `ZERO_IF(s_if)
        `ZERO_IF(b_if)
        #3;
        chk("rst_valid",    64'(m_if.valid_o), 64'd0);
        chk("rst_fwd_data", 64'(m_if.fwd_data_o), 64'd0);
        chk("rst_cnt",      64'(m_if.stall_cnt_o), 64'd0);
        chk("rst_sat_cnt",  64'(s_if.stall_cnt_o), 64'd0);
        tick();
        rst = 1'b1;

        // Plain load and forward
        m_if.valid_i = 1; m_if.regwrite_i = 1; m_if.rw_i = 5'd5; m_if.alu_i = 32'hDEAD_BEEF;
        tick();
        chk("ld_fwd_en",   64'(m_if.fwd_en_o), 64'd1);
        chk("ld_fwd_rw",   64'(m_if.fwd_rw_o), 64'd5);
        chk("ld_fwd_data", 64'(m_if.fwd_data_o), 64'hDEAD_BEEF);
        chk("ld_regwrite", 64'(m_if.regwrite_o), 64'd1);

        // Destination r0 is never forwardable
        m_if.rw_i = 5'd0;
        tick();
        chk("r0_fwd_en", 64'(m_if.fwd_en_o), 64'd0);
        chk("r0_alu",    64'(m_if.alu_o), 64'hDEAD_BEEF);

        // JAL link address wraps
        m_if.rw_i = 5'd3; m_if.jal_i = 1; m_if.pc_i = 32'hFFFF_FFFF;
        tick();
        chk("jal_fwd_data", 64'(m_if.fwd_data_o), 64'd0);
        chk("jal_pc",       64'(m_if.pc_o), 64'hFFFF_FFFF);

        // LUI result
        m_if.jal_i = 0; m_if.lui_i = 1; m_if.imm_i = 32'h0000_ABCD; m_if.alu_i = 32'h1;
        tick();
        chk("lui_fwd_data", 64'(m_if.fwd_data_o), 64'hABCD_0000);

        // Valid load to r7: load-use hazard, no forwarding
        m_if.lui_i = 0; m_if.memtoreg_i = 1; m_if.rw_i = 5'd7; m_if.alu_i = 32'h55;
        tick();
        chk("lh_hazard", 64'(m_if.load_hazard_o), 64'd1);
        chk("lh_fwd_en", 64'(m_if.fwd_en_o), 64'd0);

        // Invalid entry gates memwrite/regwrite
        m_if.valid_i = 0; m_if.memwrite_i = 1;
        tick();
        chk("inv_memwrite", 64'(m_if.memwrite_o), 64'd0);
        chk("inv_regwrite", 64'(m_if.regwrite_o), 64'd0);
        chk("inv_hazard",   64'(m_if.load_hazard_o), 64'd0);
        chk("inv_lb_copy",  64'(m_if.memtoreg_o), 64'd1);

        // Entry A
        m_if.valid_i = 1; m_if.memtoreg_i = 0; m_if.memwrite_i = 1; m_if.lb_i = 1;
        m_if.regdst_i = 1; m_if.rw_i = 5'd9; m_if.b_i = 32'hB0B0;
        m_if.imm_i = 32'h1111; m_if.pc_i = 32'h40; m_if.alu_i = 32'hA5A5;
        tick();
        chk("a_memwrite", 64'(m_if.memwrite_o), 64'd1);
        chk("a_lb",       64'(m_if.lb_o), 64'd1);
        chk("a_regdst",   64'(m_if.regdst_o), 64'd1);
        chk("a_cnt",      64'(m_if.stall_cnt_o), 64'd0);

        // Three stalled cycles with changing inputs
        m_if.stall_i = 1;
        for (int i = 0; i < 3; i++) begin
            m_if.alu_i = 32'(i); m_if.b_i = 32'(i); m_if.rw_i = 5'(i + 1);
            m_if.valid_i = 0; m_if.lb_i = 0;
            tick();
            chk("stall_alu", 64'(m_if.alu_o), 64'hA5A5);
        end
        chk("stall_b",     64'(m_if.b_o), 64'hB0B0);
        chk("stall_rw",    64'(m_if.rw_o), 64'd9);
        chk("stall_valid", 64'(m_if.valid_o), 64'd1);
        chk("stall_lb",    64'(m_if.lb_o), 64'd1);
        chk("stall_cnt",   64'(m_if.stall_cnt_o), 64'd3);

        // Flush overrides stall: bubble, data held, counter unchanged
        m_if.flush_i = 1;
        tick();
        chk("fl_valid",    64'(m_if.valid_o), 64'd0);
        chk("fl_regwrite", 64'(m_if.regwrite_o), 64'd0);
        chk("fl_memwrite", 64'(m_if.memwrite_o), 64'd0);
        chk("fl_b",        64'(m_if.b_o), 64'hB0B0);
        chk("fl_rw",       64'(m_if.rw_o), 64'd9);
        chk("fl_cnt",      64'(m_if.stall_cnt_o), 64'd3);
        chk("fl_fwd_data", 64'(m_if.fwd_data_o), 64'hA5A5);

        // First edge after stall releases loads new inputs
        m_if.stall_i = 0; m_if.flush_i = 0;
        m_if.valid_i = 1; m_if.regwrite_i = 1; m_if.memwrite_i = 0; m_if.rw_i = 5'd2; m_if.alu_i = 32'h77;
        tick();
        chk("rel_alu",    64'(m_if.alu_o), 64'h77);
        chk("rel_fwd_en", 64'(m_if.fwd_en_o), 64'd1);
        chk("rel_cnt",    64'(m_if.stall_cnt_o), 64'd3);

        // Asynchronous reset in the middle of a stall
        m_if.alu_i = 32'h1234;
        tick();
        chk("pre_rst_alu", 64'(m_if.alu_o), 64'h1234);
        m_if.stall_i = 1;
        tick();
        #2 rst = 1'b0;
        #1;
        chk("arst_alu",      64'(m_if.alu_o), 64'd0);
        chk("arst_valid",    64'(m_if.valid_o), 64'd0);
        chk("arst_fwd_en",   64'(m_if.fwd_en_o), 64'd0);
        chk("arst_fwd_data", 64'(m_if.fwd_data_o), 64'd0);
        chk("arst_cnt",      64'(m_if.stall_cnt_o), 64'd0);
        m_if.stall_i = 0;
        tick();
        rst = 1'b1;

        // Narrow counter saturates at 3
        s_if.stall_i = 1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("sat_cnt", 64'(s_if.stall_cnt_o), 64'(k > 3 ? 3 : k));
        end
        s_if.stall_i = 0;

        // Bypass follows inputs within the cycle
        b_if.alu_i = 32'h1357; b_if.valid_i = 1; b_if.memwrite_i = 1;
        #1;
        chk("byp_alu",      64'(b_if.alu_o), 64'h1357);
        chk("byp_valid",    64'(b_if.valid_o), 64'd1);
        chk("byp_memwrite", 64'(b_if.memwrite_o), 64'd1);
        b_if.alu_i = 32'h2468; b_if.stall_i = 1;
        #1;
        chk("byp_alu2", 64'(b_if.alu_o), 64'h2468);
        tick();
        chk("byp_cnt",  64'(b_if.stall_cnt_o), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
